// File: rtl/icache_fetch_prefetcher.sv
// Sequential OBI instruction prefetcher with a small response FIFO and redirect-aware discard.
// Optional same-cycle response bypass to decode: define ICACHE_FETCH_PREFETCHER_BYPASS_EN.
module icache_fetch_prefetcher #(
    parameter int FetchAddrWidth = 32,
    parameter int FetchDataWidth = 32,
    parameter int FifoDepth      = 4,
    parameter int MaxOutstanding = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      branch_i,
    input  logic [FetchAddrWidth-1:0] branch_addr_i,
    output logic                      instr_valid_o,
    input  logic                      instr_ready_i,
    output logic [FetchDataWidth-1:0] instr_rdata_o,
    output logic [FetchAddrWidth-1:0] instr_addr_o,
    output logic                      instr_err_o,
    output logic                      busy_o,
    output logic                      fetch_req_o,
    output logic [FetchAddrWidth-1:0] fetch_addr_o,
    input  logic                      fetch_gnt_i,
    input  logic                      fetch_rvalid_i,
    input  logic [FetchDataWidth-1:0] fetch_rdata_i,
    input  logic                      fetch_rerror_i
);

    localparam int Stride = FetchDataWidth / 8;
    localparam int CntW   = $clog2(MaxOutstanding + 2);
    localparam int PtrW   = $clog2(FifoDepth);
    localparam int FcntW  = $clog2(FifoDepth + 1);
    localparam logic [FetchAddrWidth-1:0] StrideA = FetchAddrWidth'(Stride);

    typedef enum logic {S_IDLE, S_FETCH} state_t;

    state_t                    r_state, w_state_nxt;
    logic [FetchAddrWidth-1:0] r_next_addr;
    logic [FetchAddrWidth-1:0] r_target;
    logic [FetchAddrWidth-1:0] r_rsp_addr;
    logic                      r_hold;
    logic                      r_redir;
    logic [CntW-1:0]           r_outstanding;
    logic [CntW-1:0]           r_discard;
    logic [PtrW-1:0]           r_wptr, r_rptr;
    logic [FcntW-1:0]          r_count;

    logic [FetchDataWidth-1:0] r_mem_data [FifoDepth];
    logic [FetchAddrWidth-1:0] r_mem_addr [FifoDepth];
    logic                      r_mem_err  [FifoDepth];

    logic                      w_credit, w_gnt, w_rv, w_pending, w_accept;
    logic                      w_fifo_empty, w_bypass, w_push, w_pop;
    logic [CntW-1:0]           w_out_nxt;
    logic [FetchAddrWidth-1:0] w_target;

    function automatic logic [FetchAddrWidth-1:0] align_addr(input logic [FetchAddrWidth-1:0] a);
        return a & ~(StrideA - FetchAddrWidth'(1));
    endfunction

    assign w_target  = align_addr(branch_addr_i);
    // Credit covers both in-flight words and buffered words so responses never need back-pressure.
    assign w_credit  = (r_outstanding < CntW'(MaxOutstanding)) &&
                       ((32'(r_count) + 32'(r_outstanding)) < 32'(FifoDepth));

    always_comb begin
        w_state_nxt = r_state;
        fetch_req_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (branch_i) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                fetch_req_o = r_hold | (~r_redir & w_credit);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_gnt        = fetch_req_o & fetch_gnt_i;
    assign w_rv         = fetch_rvalid_i;
    assign w_pending    = fetch_req_o & ~fetch_gnt_i;
    assign w_out_nxt    = r_outstanding + CntW'(w_gnt) - CntW'(w_rv);
    assign w_accept     = w_rv & (r_discard == '0) & ~branch_i;
    assign w_fifo_empty = (r_count == '0);

`ifdef ICACHE_FETCH_PREFETCHER_BYPASS_EN
    assign w_bypass = w_accept & w_fifo_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_accept & ~(w_bypass & instr_ready_i);
    assign w_pop  = ~w_fifo_empty & instr_ready_i & ~branch_i;

    assign instr_valid_o = ~w_fifo_empty | w_bypass;
    assign instr_rdata_o = w_bypass ? fetch_rdata_i :
                           (w_fifo_empty ? '0 : r_mem_data[r_rptr]);
    assign instr_addr_o  = w_bypass ? r_rsp_addr :
                           (w_fifo_empty ? '0 : r_mem_addr[r_rptr]);
    assign instr_err_o   = w_bypass ? fetch_rerror_i :
                           (w_fifo_empty ? 1'b0 : r_mem_err[r_rptr]);
    assign busy_o        = (r_outstanding != '0) | fetch_req_o;
    assign fetch_addr_o  = r_next_addr;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= S_IDLE;
            r_next_addr   <= '0;
            r_target      <= '0;
            r_rsp_addr    <= '0;
            r_hold        <= 1'b0;
            r_redir       <= 1'b0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_out_nxt;
            r_hold        <= w_pending;

            if (branch_i) begin
                r_discard <= w_out_nxt + CntW'(w_pending);
            end else if (w_rv && (r_discard != '0)) begin
                r_discard <= r_discard - CntW'(1);
            end

            // An ungranted request must finish at its old address before the new stream starts.
            if (branch_i) begin
                if (w_pending) begin
                    r_redir  <= 1'b1;
                    r_target <= w_target;
                end else begin
                    r_redir     <= 1'b0;
                    r_next_addr <= w_target;
                end
            end else if (r_redir && w_gnt) begin
                r_redir     <= 1'b0;
                r_next_addr <= r_target;
            end else if (w_gnt) begin
                r_next_addr <= r_next_addr + StrideA;
            end

            if (branch_i) begin
                r_rsp_addr <= w_target;
            end else if (w_accept) begin
                r_rsp_addr <= r_rsp_addr + StrideA;
            end

            if (branch_i) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PtrW'(1);
                if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
                r_count <= r_count + FcntW'(w_push) - FcntW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= fetch_rdata_i;
            r_mem_addr[r_wptr] <= r_rsp_addr;
            r_mem_err[r_wptr]  <= fetch_rerror_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(w_rv && (r_outstanding == '0)));
            assert (!(w_gnt && !w_rv && (r_outstanding == CntW'(MaxOutstanding))));
            assert (!(w_push && !w_pop && (32'(r_count) == 32'(FifoDepth))));
        end
    end

endmodule

// File: tb/tb_icache_fetch_prefetcher.sv
// Bench for icache_fetch_prefetcher: in-order cache model plus a stream-level reference of
// the instruction words decode should see (sequential words from the latest branch target).
module tb_icache_fetch_prefetcher;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_addr_o;
    logic        instr_err_o;
    logic        busy_o;
    logic        fetch_req_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_gnt_i = 1'b0;
    logic        fetch_rvalid_i = 1'b0;
    logic [31:0] fetch_rdata_i = '0;
    logic        fetch_rerror_i = 1'b0;

    icache_fetch_prefetcher dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .instr_valid_o  (instr_valid_o),
        .instr_ready_i  (instr_ready_i),
        .instr_rdata_o  (instr_rdata_o),
        .instr_addr_o   (instr_addr_o),
        .instr_err_o    (instr_err_o),
        .busy_o         (busy_o),
        .fetch_req_o    (fetch_req_o),
        .fetch_addr_o   (fetch_addr_o),
        .fetch_gnt_i    (fetch_gnt_i),
        .fetch_rvalid_i (fetch_rvalid_i),
        .fetch_rdata_i  (fetch_rdata_i),
        .fetch_rerror_i (fetch_rerror_i)
    );

    always #5 clk = ~clk;

`ifdef ICACHE_FETCH_PREFETCHER_BYPASS_EN
    localparam int ExpLat = 2;
`else
    localparam int ExpLat = 3;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    // stimulus knobs: 0 = never, 1 = always, 2 = random
    logic        rst_n = 1'b0;
    logic        br = 1'b0;
    logic [31:0] br_addr = '0;
    logic        rdy = 1'b0;
    bit          rdy_rand = 1'b0;
    int          gnt_mode = 0;
    int          rv_mode = 0;
    logic [31:0] err_addr = 32'h1;

    // reference state
    logic [31:0] q[$];
    logic [31:0] gnt_log[$];
    logic [31:0] pop_log[$];
    logic        err_log[$];
    logic [31:0] exp_addr = '0;
    bit          exp_ok = 1'b0;
    bit          prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;
    int          n_pops = 0;

    // sampled DUT outputs of the last stepped cycle
    logic        s_req, s_valid, s_busy, s_ierr;
    logic [31:0] s_addr, s_iaddr, s_idata;

    function automatic logic [31:0] dfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic efn(input logic [31:0] a);
        return (a == err_addr) || (a[6:2] == 5'd19);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit g, v, pop;
        @(negedge clk);
        rst_ni        = rst_n;
        branch_i      = br;
        branch_addr_i = br_addr;
        instr_ready_i = rdy_rand ? 1'($urandom_range(1)) : rdy;
        g = (gnt_mode == 1) || (gnt_mode == 2 && $urandom_range(99) < 60);
        fetch_gnt_i = g & fetch_req_o;
        v = rst_n && (q.size() > 0) && (rv_mode == 1 || (rv_mode == 2 && $urandom_range(99) < 50));
        fetch_rvalid_i = v;
        fetch_rdata_i  = v ? dfn(q[0]) : $urandom;
        fetch_rerror_i = v ? efn(q[0]) : 1'($urandom_range(1));
        #1;
        s_req = fetch_req_o;  s_addr = fetch_addr_o;  s_busy = busy_o;
        s_valid = instr_valid_o;  s_iaddr = instr_addr_o;  s_idata = instr_rdata_o;  s_ierr = instr_err_o;
        pop = s_valid && instr_ready_i && !br;
        if (rst_n) begin
            if (prev_pend) begin
                check("req_held", s_req, 1);
                check("req_addr_held", s_addr, prev_addr);
            end
            check("busy", s_busy, (q.size() != 0) || s_req);
            if (q.size() >= 2) check("max_outstanding", s_req, 0);
            if (s_req) check("req_aligned", s_addr[1:0], 0);
            if (!exp_ok) check("valid_before_branch", s_valid, 0);
            else if (pop) begin
                check("pop_addr", s_iaddr, exp_addr);
                check("pop_data", s_idata, dfn(exp_addr));
                check("pop_err", 32'(s_ierr), 32'(efn(exp_addr)));
                pop_log.push_back(s_iaddr);
                err_log.push_back(s_ierr);
                n_pops++;
                exp_addr += 32'd4;
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            exp_ok = 1'b0;
            prev_pend = 1'b0;
        end else begin
            if (v) void'(q.pop_front());
            if (s_req && fetch_gnt_i) begin
                q.push_back(s_addr);
                gnt_log.push_back(s_addr);
            end
            prev_pend = s_req && !fetch_gnt_i;
            prev_addr = s_addr;
            if (br) begin
                exp_ok = 1'b1;
                exp_addr = br_addr & ~32'd3;
            end
        end
    endtask

    task automatic do_branch(input logic [31:0] a);
        br = 1'b1;
        br_addr = a;
        step();
        br = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // reset state
        step();
        check("rst_valid", s_valid, 0);
        check("rst_req", s_req, 0);
        check("rst_busy", s_busy, 0);
        check("rst_fetch_addr", s_addr, 0);
        check("rst_instr_addr", s_iaddr, 0);
        check("rst_instr_data", s_idata, 0);
        check("rst_instr_err", s_ierr, 0);

        // streaming at full speed, first-word latency
        gnt_mode = 1; rv_mode = 1; rdy = 1'b1;
        pop_log.delete();
        do_branch(32'h0000_1000);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (s_valid && lat == 0) lat = k;
        end
        check("first_valid_latency", lat, ExpLat);
        check("stream_pops", 32'(pop_log.size() >= 3), 1);
        if (pop_log.size() >= 3) begin
            check("stream_a0", pop_log[0], 32'h0000_1000);
            check("stream_a1", pop_log[1], 32'h0000_1004);
            check("stream_a2", pop_log[2], 32'h0000_1008);
        end

        // decode stalled: credits cap grants at the FIFO depth
        reset_dut();
        gnt_mode = 1; rv_mode = 1; rdy = 1'b0;
        gnt_log.delete();
        do_branch(32'h0000_3000);
        for (int k = 0; k < 15; k++) step();
        check("stall_grants", gnt_log.size(), 4);
        check("stall_req_low", s_req, 0);
        rdy = 1'b1;
        step();
        check("release_valid", s_valid, 1);
        check("release_req_same_cycle", s_req, 0);
        step();
        check("release_req_next", s_req, 1);
        check("release_req_addr", s_addr, 32'h0000_3010);
        for (int k = 0; k < 10; k++) step();

        // redirect with one outstanding, one buffered and one pending ungranted request
        reset_dut();
        gnt_mode = 1; rv_mode = 0; rdy = 1'b0;
        do_branch(32'h0000_1000);
        step();
        step();
        gnt_mode = 0; rv_mode = 1;
        step();
        check("redir_credit_block", s_req, 0);
        rv_mode = 0;
        br = 1'b1; br_addr = 32'h0000_2001;
        step();
        br = 1'b0;
        check("redir_pending_req", s_req, 1);
        check("redir_pending_addr", s_addr, 32'h0000_1008);
        gnt_mode = 1;
        gnt_log.delete();
        pop_log.delete();
        step();
        check("redir_old_req_kept", s_req, 1);
        check("redir_old_addr_kept", s_addr, 32'h0000_1008);
        rv_mode = 1; rdy = 1'b1;
        for (int k = 0; k < 20; k++) step();
        check("redir_grants", 32'(gnt_log.size() >= 2), 1);
        if (gnt_log.size() >= 2) begin
            check("redir_g0", gnt_log[0], 32'h0000_1008);
            check("redir_g1", gnt_log[1], 32'h0000_2000);
        end
        check("redir_pops", 32'(pop_log.size() >= 1), 1);
        if (pop_log.size() >= 1) check("redir_first_pop", pop_log[0], 32'h0000_2000);

        // error word in the middle of a stream
        reset_dut();
        err_addr = 32'h0000_1004;
        gnt_mode = 1; rv_mode = 1; rdy = 1'b1;
        pop_log.delete(); err_log.delete();
        do_branch(32'h0000_1000);
        for (int k = 0; k < 10; k++) step();
        check("err_pops", 32'(pop_log.size() >= 3), 1);
        if (pop_log.size() >= 3) begin
            check("err_word_addr", pop_log[1], 32'h0000_1004);
            check("err_word_flag", err_log[1], 1);
            check("after_err_addr", pop_log[2], 32'h0000_1008);
            check("after_err_flag", err_log[2], 0);
        end
        err_addr = 32'h1;

        // address wrap at the top of the space
        reset_dut();
        gnt_mode = 1; rv_mode = 1; rdy = 1'b1;
        gnt_log.delete();
        do_branch(32'hFFFF_FFF8);
        for (int k = 0; k < 6; k++) step();
        check("wrap_grants", 32'(gnt_log.size() >= 3), 1);
        if (gnt_log.size() >= 3) begin
            check("wrap_g0", gnt_log[0], 32'hFFFF_FFF8);
            check("wrap_g1", gnt_log[1], 32'hFFFF_FFFC);
            check("wrap_g2", gnt_log[2], 32'h0000_0000);
        end

        // reset mid-operation with words buffered and requests in flight
        reset_dut();
        gnt_mode = 1; rv_mode = 0; rdy = 1'b0;
        do_branch(32'h0000_5000);
        step();
        step();
        gnt_mode = 0; rv_mode = 1;
        step();
        step();
        gnt_mode = 1; rv_mode = 0;
        step();
        step();
        check("pre_reset_outstanding", q.size(), 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        gnt_mode = 1;
        step();
        check("post_reset_valid", s_valid, 0);
        check("post_reset_req", s_req, 0);
        check("post_reset_busy", s_busy, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("idle_no_req", s_req, 0);
        end
        do_branch(32'h0000_6000);
        step();
        check("restart_req", s_req, 1);
        check("restart_addr", s_addr, 32'h0000_6000);

        // randomized traffic with random redirects
        reset_dut();
        gnt_mode = 2; rv_mode = 2; rdy_rand = 1'b1;
        n_pops = 0;
        do_branch($urandom);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(99) < 3) begin
                br = 1'b1;
                br_addr = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            end
            step();
            br = 1'b0;
        end
        check("random_progress", 32'(n_pops > 100), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
